// File: rtl/sensor_link_pkg.sv
`default_nettype none
// ============================================================================
// sensor_link_pkg : shared types and keys for the sensor/arbiter link
// Rev 1.0
// ============================================================================
package sensor_link_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_DATA  = 3'd1,
    WAIT_DATA  = 3'd2,
    SEND_CHECK = 3'd3,
    WAIT_CHECK = 3'd4,
    GUARD      = 3'd5
  } state_t;

  // Normal-response key is shared with the arbiter's checksum test.
  localparam logic [7:0] LINK_CHECK_KEY = 8'h37;
  localparam logic [7:0] LINK_ALARM_KEY = 8'hC8;

  function automatic logic [7:0] check_byte(input logic [7:0] data,
                                            input logic [7:0] key);
    return data ^ key;
  endfunction

endpackage
`default_nettype wire

// File: rtl/responder_guard_timer.sv
`default_nettype none
// ============================================================================
// responder_guard_timer : loadable down-counter with zero flag
// Rev 1.0
// ============================================================================
module responder_guard_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority; decrement stops at zero rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sensor_responder.sv
`default_nettype none
// ============================================================================
// sensor_responder : answers addressed requests with data+check byte packets
//                    and sends one unsolicited alarm packet per alarm edge
// Rev 1.0
// ============================================================================
module sensor_responder
  import sensor_link_pkg::*;
#(
  parameter logic [7:0]  SENSOR_ID   = 8'h01,
  parameter logic [7:0]  CHECK_KEY   = LINK_CHECK_KEY,
  parameter logic [7:0]  ALARM_KEY   = LINK_ALARM_KEY,
  parameter logic [7:0]  ALARM_LEVEL = 8'hF0,
  parameter logic [15:0] GUARD_CLKS  = 16'd870
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  input  logic       tx_done,
  input  logic       tx_active,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       sensor_valid,
  input  logic [7:0] sensor_value,
  input  logic       alarm_en,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  state_t     state_q,      state_d;
  logic [7:0] sample_q,     sample_d;
  logic       alarm_prev_q, alarm_prev_d;
  logic       pending_q,    pending_d;
  logic [7:0] pkt_q,        pkt_d;
  logic [7:0] key_q,        key_d;
  logic       tx_dv_q,      tx_dv_d;
  logic [7:0] tx_byte_q,    tx_byte_d;
  logic       busy_q,       busy_d;
  logic [7:0] drop_cnt_q,   drop_cnt_d;

  logic alarm_c;
  logic alarm_edge;
  logic req_match;
  logic timer_load;
  logic timer_dec;
  logic timer_zero;

  assign alarm_c    = alarm_en && (sample_q >= ALARM_LEVEL);
  assign alarm_edge = alarm_c && !alarm_prev_q;
  assign req_match  = rx_dv && (rx_byte == SENSOR_ID);

  responder_guard_timer #(
    .WIDTH (16)
  ) u_guard_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (GUARD_CLKS - 16'd1),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_comb begin
    state_d      = state_q;
    sample_d     = sensor_valid ? sensor_value : sample_q;
    alarm_prev_d = alarm_c;
    pending_d    = pending_q | alarm_edge;
    pkt_d        = pkt_q;
    key_d        = key_q;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    drop_cnt_d   = drop_cnt_q;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;

    if (req_match && (state_q != IDLE) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Launch strobes are issued on the transition into SEND_*, so tx_dv
    // is high exactly while state_q is SEND_* and the launch was allowed.
    case (state_q)
      IDLE: begin
        if (req_match) begin
          pkt_d     = sample_q;
          key_d     = CHECK_KEY;
          tx_byte_d = sample_q;
          tx_dv_d   = !tx_active;
          state_d   = SEND_DATA;
        end else if (pending_q) begin
          pkt_d     = sample_q;
          key_d     = ALARM_KEY;
          pending_d = alarm_edge;
          tx_byte_d = sample_q;
          tx_dv_d   = !tx_active;
          state_d   = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (tx_dv_q) begin
          state_d = WAIT_DATA;
        end else if (!tx_active) begin
          tx_dv_d = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (tx_done) begin
          tx_byte_d = check_byte(pkt_q, key_q);
          tx_dv_d   = !tx_active;
          state_d   = SEND_CHECK;
        end
      end
      SEND_CHECK: begin
        if (tx_dv_q) begin
          state_d = WAIT_CHECK;
        end else if (!tx_active) begin
          tx_dv_d = 1'b1;
        end
      end
      WAIT_CHECK: begin
        if (tx_done) begin
          if (GUARD_CLKS == 16'd0) begin
            state_d = IDLE;
          end else begin
            timer_load = 1'b1;
            state_d    = GUARD;
          end
        end
      end
      GUARD: begin
        if (timer_zero) begin
          state_d = IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sample_q     <= 8'h00;
      alarm_prev_q <= 1'b0;
      pending_q    <= 1'b0;
      pkt_q        <= 8'h00;
      key_q        <= 8'h00;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
      busy_q       <= 1'b0;
      drop_cnt_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      alarm_prev_q <= alarm_prev_d;
      pending_q    <= pending_d;
      pkt_q        <= pkt_d;
      key_q        <= key_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign tx_dv    = tx_dv_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_responder.sv
`default_nettype none
// ============================================================================
// tb_sensor_responder : directed scoreboard bench with a behavioural uart_tx
// Rev 1.0
// ============================================================================
module tb_sensor_responder;

  localparam logic [15:0] TB_GUARD_CLKS = 16'd16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_done   = 1'b0;
  logic       tx_active = 1'b0;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       sensor_valid;
  logic [7:0] sensor_value;
  logic       alarm_en;
  logic       busy;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  int byte_clks = 20;
  int uart_cnt  = 0;
  logic [7:0] exp_q[$];

  sensor_responder #(
    .SENSOR_ID   (8'h01),
    .CHECK_KEY   (8'h37),
    .ALARM_KEY   (8'hC8),
    .ALARM_LEVEL (8'hF0),
    .GUARD_CLKS  (TB_GUARD_CLKS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_dv        (rx_dv),
    .rx_byte      (rx_byte),
    .tx_done      (tx_done),
    .tx_active    (tx_active),
    .tx_dv        (tx_dv),
    .tx_byte      (tx_byte),
    .sensor_valid (sensor_valid),
    .sensor_value (sensor_value),
    .alarm_en     (alarm_en),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clock = ~clock;

  // uart_tx model: not reset by the DUT reset, so an interrupted byte finishes.
  always @(posedge clock) begin
    tx_done <= 1'b0;
    if (tx_active) begin
      if (uart_cnt <= 1) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
      end else begin
        uart_cnt <= uart_cnt - 1;
      end
    end else if (tx_dv) begin
      tx_active <= 1'b1;
      uart_cnt  <= byte_clks;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (tx_dv === 1'b1) begin
      chk("tx_dv_while_active", 32'(tx_active), 32'd0);
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_tx observed=%0h expected=none", tx_byte);
      end
      if (exp_q.size() != 0) chk("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
    end
  end

  task automatic set_sample(input logic [7:0] v);
    @(negedge clock);
    sensor_valid = 1'b1;
    sensor_value = v;
    @(negedge clock);
    sensor_valid = 1'b0;
  endtask

  task automatic send_req(input logic [7:0] id);
    @(negedge clock);
    rx_dv   = 1'b1;
    rx_byte = id;
    @(negedge clock);
    rx_dv   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clock);
      n++;
      if (!busy && !tx_active) quiet++;
      else quiet = 0;
    end
    chk(tag, 32'(quiet >= 4), 32'd1);
  endtask

  task automatic push2(input logic [7:0] d, input logic [7:0] c);
    exp_q.push_back(d);
    exp_q.push_back(c);
  endtask

  initial begin
    int hits;
    int n;
    reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    sensor_valid = 1'b0; sensor_value = 8'h00; alarm_en = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h00);
    reset = 1'b0;

    // Basic request: 5A then 5A^37
    set_sample(8'h5A);
    push2(8'h5A, 8'h6D);
    send_req(8'h01);
    chk("t1_latency_tx_dv", 32'(tx_dv), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1_idle");
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    chk("t1_drop", 32'(drop_cnt), 32'h00);

    // Other address is ignored
    send_req(8'h02);
    hits = 0;
    repeat (10) begin
      @(negedge clock);
      if (busy || tx_dv) hits++;
    end
    chk("t2_ignored", 32'(hits), 32'd0);
    chk("t2_drop", 32'(drop_cnt), 32'h00);

    // Alarm edge: one packet F3, F3^C8; a held level gives no more
    alarm_en = 1'b1;
    set_sample(8'h10);
    repeat (3) @(negedge clock);
    chk("t3_below_level", 32'(busy), 32'd0);
    push2(8'hF3, 8'h3B);
    set_sample(8'hF3);
    wait_idle("t3_idle");
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    hits = 0;
    repeat (40) begin
      @(negedge clock);
      sensor_valid = 1'b1;
      sensor_value = 8'hF3;
      if (busy) hits++;
    end
    sensor_valid = 1'b0;
    chk("t3_no_repeat", 32'(hits), 32'd0);

    // Request and alarm edge in the same cycle: request first, alarm after guard
    set_sample(8'h10);
    repeat (3) @(negedge clock);
    push2(8'hF5, 8'hC2);
    push2(8'hF5, 8'h3D);
    @(negedge clock);
    sensor_valid = 1'b1;
    sensor_value = 8'hF5;
    @(negedge clock);
    sensor_valid = 1'b0;
    rx_dv   = 1'b1;
    rx_byte = 8'h01;
    @(negedge clock);
    rx_dv   = 1'b0;
    chk("t4_latency_tx_dv", 32'(tx_dv), 32'd1);
    wait_idle("t4_idle");
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_drop", 32'(drop_cnt), 32'h00);

    // Drop counter saturation during a long data byte
    alarm_en = 1'b0;
    set_sample(8'h22);
    byte_clks = 400;
    push2(8'h22, 8'h15);
    send_req(8'h01);
    chk("t5_latency_tx_dv", 32'(tx_dv), 32'd1);
    send_req(8'h02);
    chk("t5_nonmatch_no_drop", 32'(drop_cnt), 32'h00);
    repeat (254) begin
      @(negedge clock);
      rx_dv   = 1'b1;
      rx_byte = 8'h01;
    end
    @(negedge clock);
    rx_dv = 1'b0;
    chk("t5_drop_fe", 32'(drop_cnt), 32'hFE);
    repeat (46) begin
      @(negedge clock);
      rx_dv   = 1'b1;
      rx_byte = 8'h01;
    end
    @(negedge clock);
    rx_dv = 1'b0;
    chk("t5_drop_sat", 32'(drop_cnt), 32'hFF);
    chk("t5_still_busy", 32'(busy), 32'd1);
    byte_clks = 20;
    wait_idle("t5_idle");
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // Reset during WAIT_CHECK, then a normal request (sample cleared by reset)
    set_sample(8'h5A);
    push2(8'h5A, 8'h6D);
    send_req(8'h01);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("t6_check_sent", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("t6_rst_drop", 32'(drop_cnt), 32'h00);
    push2(8'h00, 8'h37);
    send_req(8'h01);
    wait_idle("t6_idle");
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
